// File: rtl/cdb_round_robin_scheduler.sv
// cdb_round_robin_scheduler: two-class round-robin CDB arbiter with starvation relief and registered broadcast
module cdb_round_robin_scheduler #(
    parameter int REQUESTERS = 4,
    parameter int DATA_WIDTH = 4,
    parameter int CDB_TAG_WIDTH = 4,
    parameter logic [REQUESTERS-1:0] HIGH_PRIO_MASK = 4'b0001,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQUESTERS-1:0]               req,
    input  logic [REQUESTERS*CDB_TAG_WIDTH-1:0] req_tag,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]    req_data,
    output logic [REQUESTERS-1:0]               grant,
    output logic                                cdb_valid,
    output logic [CDB_TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]               cdb_data,
    output logic [$clog2(REQUESTERS)-1:0]       cdb_source
);
    localparam int SW = $clog2(REQUESTERS);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] ptr_hi, ptr_lo, win, nxt;
    logic [CW-1:0] starve_cnt;
    logic [REQUESTERS-1:0] hi_req, lo_req;
    logic hi_pend, lo_pend, sel_lo, found;
    logic [SW:0] pk;

    // Scan offsets high to low so the nearest requester after the pointer wins last.
    function automatic logic [SW:0] pick(input logic [REQUESTERS-1:0] r, input logic [SW-1:0] p);
        pick = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(p) + k) % REQUESTERS;
            if (r[idx]) pick = {1'b1, idx[SW-1:0]};
        end
    endfunction

    assign hi_req  = req & HIGH_PRIO_MASK;
    assign lo_req  = req & ~HIGH_PRIO_MASK;
    assign hi_pend = |hi_req;
    assign lo_pend = |lo_req;
    assign sel_lo  = lo_pend && (!hi_pend || starve_cnt == CW'(STARVE_LIMIT));
    assign pk      = pick(sel_lo ? lo_req : hi_req, sel_lo ? ptr_lo : ptr_hi);
    assign found   = pk[SW];
    assign win     = pk[SW-1:0];
    assign nxt     = (win == SW'(REQUESTERS - 1)) ? '0 : win + 1'b1;

    always_comb begin
        grant = '0;
        grant[win] = found & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_source <= '0;
            ptr_hi     <= '0;
            ptr_lo     <= '0;
            starve_cnt <= '0;
        end else begin
            cdb_valid <= found;
            if (found) begin
                cdb_tag    <= req_tag[int'(win)*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
                cdb_data   <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                cdb_source <= win;
                if (sel_lo) ptr_lo <= nxt;
                else ptr_hi <= nxt;
            end
            starve_cnt <= (!lo_pend || sel_lo) ? '0 :
                          (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_round_robin_scheduler.sv
// tb_cdb_round_robin_scheduler: scenario tasks with a broadcast scoreboard for the CDB scheduler
module tb_cdb_round_robin_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req = '0;
    logic [15:0] req_tag = '0;
    logic [15:0] req_data = '0;
    logic [3:0] grant;
    logic cdb_valid;
    logic [3:0] cdb_tag;
    logic [3:0] cdb_data;
    logic [1:0] cdb_source;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] d;
        logic [1:0] s;
    } bc_t;

    bc_t sb[$];
    bc_t bc_obs, e;
    logic [3:0] g_obs;
    logic v_obs;
    int total = 0;
    int bad = 0;

    cdb_round_robin_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data),
        .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_source(cdb_source)
    );

    always #5 clk = ~clk;

    // Expected broadcast comes from the stimulus slice of the producer the test says should win.
    task automatic expect_win(input logic [3:0] eg);
        for (int i = 0; i < 4; i++)
            if (eg[i]) sb.push_back({req_tag[i*4 +: 4], req_data[i*4 +: 4], 2'(i)});
    endtask

    // Called at negedge: sample grant, cross the posedge, sample broadcast, then a granted producer moves on.
    task automatic tick(input logic [3:0] eg);
        #1 g_obs = grant;
        @(posedge clk);
        #1 v_obs = cdb_valid;
        bc_obs = {cdb_tag, cdb_data, cdb_source};
        for (int i = 0; i < 4; i++)
            if (eg[i]) req_data[i*4 +: 4] = req_data[i*4 +: 4] + 4'd1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_source} !== 11'd0)
            begin bad++; $display("FAIL reset_outputs got=%b want=0", {cdb_valid, cdb_tag, cdb_data, cdb_source}); end
        total++;
        if (dut.starve_cnt !== 2'd0) begin bad++; $display("FAIL reset_starve got=%0d want=0", dut.starve_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        req_tag[11:8] = 4'd5;
        req_data[11:8] = 4'd9;
        expect_win(4'b0100);
        tick(4'b0100);
        req = '0;
        e = sb.pop_front();
        total++;
        if (g_obs !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", g_obs); end
        total++;
        if (!v_obs || bc_obs !== e) begin bad++; $display("FAIL single_bcast got=%b/%h want=1/%h", v_obs, bc_obs, e); end
        tick(4'b0000);
        total++;
        if (g_obs !== 4'b0000 || v_obs !== 1'b0) begin bad++; $display("FAIL single_idle got=%b/%b want=0000/0", g_obs, v_obs); end
        total++;
        if (bc_obs !== e) begin bad++; $display("FAIL single_hold got=%h want=%h", bc_obs, e); end
    endtask

    task automatic run_seq(input string nm, input logic [3:0] r, input int n,
                           input logic [3:0] eg [8], input logic chk_sc, input logic [1:0] sc [8]);
        req = r;
        for (int c = 0; c < n; c++) begin
            expect_win(eg[c]);
            tick(eg[c]);
            total++;
            if (g_obs !== eg[c]) begin bad++; $display("FAIL %s_grant c=%0d got=%b want=%b", nm, c, g_obs, eg[c]); end
            if (eg[c] != 0) begin
                e = sb.pop_front();
                total++;
                if (!v_obs || bc_obs !== e) begin bad++; $display("FAIL %s_bcast c=%0d got=%b/%h want=1/%h", nm, c, v_obs, bc_obs, e); end
            end else begin
                total++;
                if (v_obs !== 1'b0) begin bad++; $display("FAIL %s_valid c=%0d got=%b want=0", nm, c, v_obs); end
            end
            if (chk_sc) begin
                total++;
                if (dut.starve_cnt !== sc[c]) begin bad++; $display("FAIL %s_starve c=%0d got=%0d want=%0d", nm, c, dut.starve_cnt, sc[c]); end
            end
        end
    endtask

    task automatic test_low_rr();
        logic [3:0] eg [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 0, 0, 0, 0};
        logic [1:0] sc [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        req_tag = 16'hDCBA;
        req_data = 16'h4321;
        run_seq("low_rr", 4'b1110, 4, eg, 1'b1, sc);
    endtask

    task automatic test_starvation();
        logic [3:0] eg [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [1:0] sc [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        do_reset();
        req_tag = 16'h7E3C;
        req_data = 16'h0A50;
        run_seq("starve", 4'b0011, 8, eg, 1'b1, sc);
    endtask

    task automatic test_high_stream();
        logic [3:0] eg [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic [1:0] sc [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        req_tag = 16'h0006;
        req_data = 16'h0000;
        run_seq("hi_a", 4'b0001, 8, eg, 1'b1, sc);
        run_seq("hi_b", 4'b0001, 8, eg, 1'b1, sc);
        run_seq("hi_wrap", 4'b0001, 2, eg, 1'b1, sc);
    endtask

    task automatic test_reset_mid();
        logic [3:0] eg [8] = '{4'b0010, 4'b0100, 0, 0, 0, 0, 0, 0};
        logic [3:0] eg2 [8] = '{4'b0010, 0, 0, 0, 0, 0, 0, 0};
        logic [1:0] sc [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        req_tag = 16'h9876;
        req_data = 16'h5555;
        run_seq("rmid_pre", 4'b1110, 2, eg, 1'b0, sc);
        rst = 1'b1;
        #1;
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_grant got=%b want=0000", grant); end
        @(posedge clk);
        #1;
        total++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_source} !== 11'd0)
            begin bad++; $display("FAIL rmid_outputs got=%b want=0", {cdb_valid, cdb_tag, cdb_data, cdb_source}); end
        @(negedge clk);
        rst = 1'b0;
        run_seq("rmid_post", 4'b1110, 1, eg2, 1'b0, sc);
    endtask

    task automatic test_idle_gap();
        logic [3:0] eg1 [8] = '{4'b0001, 4'b0001, 0, 0, 0, 0, 0, 0};
        logic [3:0] eg0 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        logic [3:0] eg2 [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 0, 0, 0, 0};
        logic [1:0] sc1 [8] = '{1, 2, 0, 0, 0, 0, 0, 0};
        logic [1:0] sc0 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        logic [1:0] sc2 [8] = '{1, 2, 3, 0, 0, 0, 0, 0};
        do_reset();
        req_tag = 16'h3142;
        req_data = 16'h0B0C;
        run_seq("gap_a", 4'b0011, 2, eg1, 1'b1, sc1);
        run_seq("gap_idle", 4'b0000, 1, eg0, 1'b1, sc0);
        run_seq("gap_b", 4'b0011, 4, eg2, 1'b1, sc2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_low_rr();
        test_starvation();
        test_high_stream();
        test_reset_mid();
        test_idle_gap();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_round_robin_scheduler.md
# cdb_round_robin_scheduler

Arbitrates the common data bus (CDB) among up to REQUESTERS result producers (ALU execution unit, future load/store and branch units) and drives the registered CDB broadcast seen by every consumer (reservation stations, register file controller). Two priority classes, round-robin within each class, and a starvation counter that forces the low class through after STARVE_LIMIT consecutive high-class wins. It replaces the purely combinational single-input priority arbiter once more than one producer exists.

## Interface
- REQUESTERS, 4: number of CDB producers; must be ≥ 2.
- DATA_WIDTH, 4: CDB data width.
- CDB_TAG_WIDTH, 4: CDB tag width; must be ≤ DATA_WIDTH.
- HIGH_PRIO_MASK, 4'b0001: bit i set means requester i is in the high class.
- STARVE_LIMIT, 3: consecutive high-class grants tolerated while low-class requests wait; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  REQUESTERS  bit i: producer i holds a result for the CDB.
- req_tag  in  REQUESTERS*CDB_TAG_WIDTH  packed; slice i is producer i's tag.
- req_data  in  REQUESTERS*DATA_WIDTH  packed; slice i is producer i's data.
- grant  out  REQUESTERS  one-hot or zero, combinational; the result of producer i is taken at this posedge.
- cdb_valid  out  1  registered; a broadcast is on the bus this cycle.
- cdb_tag  out  CDB_TAG_WIDTH  registered broadcast tag.
- cdb_data  out  DATA_WIDTH  registered broadcast data.
- cdb_source  out  $clog2(REQUESTERS)  registered index of the producer being broadcast.

## Operation
- State:
  - ptr_hi and ptr_lo, round-robin pointers, $clog2(REQUESTERS) bits each.
  - starve_cnt, saturating counter, 0..STARVE_LIMIT.
  - Output registers.
- Class pending:
  - hi_pend = |(req & HIGH_PRIO_MASK).
  - lo_pend = |(req & ~HIGH_PRIO_MASK).
- Class selection (combinational):
  - If lo_pend and (!hi_pend or starve_cnt == STARVE_LIMIT), the low class is selected.
  - Otherwise, if hi_pend, the high class is selected.
  - Otherwise nothing is selected.
- Within the selected class, the winner is the first requester with req set and in that class. The search starts at the class pointer and wraps modulo REQUESTERS. grant is that bit.
- grant is forced to 0 while rst is high.
- On posedge with a winner w:
  - cdb_valid ← 1, cdb_tag ← req_tag[w], cdb_data ← req_data[w], cdb_source ← w.
  - The selected class pointer ← (w+1) mod REQUESTERS. The other pointer is unchanged.
- On posedge with no winner: cdb_valid ← 0. tag, data and source hold their previous values.
- starve_cnt update on each non-reset posedge:
  - High-class grant with lo_pend: starve_cnt ← min(starve_cnt+1, STARVE_LIMIT).
  - Low-class grant: starve_cnt ← 0.
  - lo_pend is 0: starve_cnt ← 0.
- Producer handshake:
  - A producer holds req, tag and data stable until it samples grant=1 at a posedge.
  - In the next cycle it may deassert req or present a new result.
  - A producer never withdraws req without a grant.
- Reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_source=0, ptr_hi=0, ptr_lo=0, starve_cnt=0.

## Timing
- Arbitration is combinational in the request cycle N. Broadcast appears in cycle N+1 for exactly one cycle per grant.
- Back-to-back grants give a continuous cdb_valid=1, with a new tag and data every cycle. Throughput is 1 result per cycle.
- At most one grant per cycle. Simultaneous requests from both classes resolve as in Operation, with no extra cycle.
- Pointer wrap: a winner at index REQUESTERS-1 sets the pointer to 0.
- When the pointer indexes a non-class or idle bit, the search skips it in the same cycle.
- Reset mid-broadcast: the cycle after the rst posedge shows cdb_valid=0. A pending producer sees grant=0 and keeps its request. After rst falls, arbitration restarts from pointer 0.
- An all-ones or all-zeros HIGH_PRIO_MASK is legal. The empty class is never selected, and starve_cnt stays 0.

## Test plan
- Single request, parameters at default:
  - Stimulus: req=0100, tag 5, data 9 in cycle 0, dropped after the grant.
  - Response: grant=0100 in cycle 0. Cycle 1 has cdb_valid=1, cdb_tag=5, cdb_data=9, cdb_source=2. Cycle 2 has cdb_valid=0.
- Low-class round robin:
  - Stimulus: req=1110 held for 4 cycles after reset.
  - Response: grants 0010, 0100, 1000, 0010. cdb_valid stays 1 from cycle 1.
- Starvation relief:
  - Stimulus: req=0011 held.
  - Response: grants 0001, 0001, 0001, 0010, 0001, 0001, 0001, 0010. starve_cnt sequence is 1, 2, 3, 0.
- High-only stream:
  - Stimulus: req=0001 held, data incrementing 0..15.
  - Response: grant=0001 every cycle. cdb_data follows one cycle later and wraps 15→0. starve_cnt stays 0.
- Reset mid-operation:
  - Stimulus: assert rst while cdb_valid=1 with req=1110.
  - Response: grant=0 during rst. The next cycle has cdb_valid=0 and cdb_tag/data/source=0. The first grant after release is 0010.
- Idle gap:
  - Stimulus: req=0011 for 2 cycles, then req=0000 for 1 cycle, then req=0011.
  - Response: grants 0001, 0001, none, 0001, 0001, 0001, 0010, because starve_cnt cleared in the idle cycle. cdb_valid is 0 exactly one cycle after the idle cycle.
